// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 Hz timing constants and raster phase type
//                for the VGA timing generator and the downstream renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned c_POS_W     = 10;

    localparam int unsigned c_H_VISIBLE = 640;
    localparam int unsigned c_H_FRONT   = 16;
    localparam int unsigned c_H_SYNC    = 96;
    localparam int unsigned c_H_BACK    = 48;
    localparam int unsigned c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;

    localparam int unsigned c_V_VISIBLE = 480;
    localparam int unsigned c_V_FRONT   = 10;
    localparam int unsigned c_V_SYNC    = 2;
    localparam int unsigned c_V_BACK    = 33;
    localparam int unsigned c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    // Raster region along one axis
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/vga_axis_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_timer
//  Description : One raster axis: position counter, region FSM, look-ahead
//                sync decode (from next position) and wrap strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE = c_H_VISIBLE,
    parameter int unsigned FRONT   = c_H_FRONT,
    parameter int unsigned SYNC    = c_H_SYNC,
    parameter int unsigned BACK    = c_H_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance_i,
    output logic [c_POS_W-1:0] pos_o,
    output phase_e             phase_o,
    output logic               sync_next_o,
    output logic               wrap_o
);

    localparam int unsigned c_TOTAL = VISIBLE + FRONT + SYNC + BACK;

    localparam logic [c_POS_W-1:0] c_LAST_ACTIVE = c_POS_W'(VISIBLE - 1);
    localparam logic [c_POS_W-1:0] c_LAST_FRONT  = c_POS_W'(VISIBLE + FRONT - 1);
    localparam logic [c_POS_W-1:0] c_SYNC_START  = c_POS_W'(VISIBLE + FRONT);
    localparam logic [c_POS_W-1:0] c_LAST_SYNC   = c_POS_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [c_POS_W-1:0] c_LAST        = c_POS_W'(c_TOTAL - 1);

    // Every region must exist and the total must fit the 10-bit counter
    generate
        if (VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 || c_TOTAL >= 1024) begin : g_param_error
            $error("vga_axis_timer: invalid timing parameters");
        end
    endgenerate

    logic [c_POS_W-1:0] pos_q;
    logic [c_POS_W-1:0] pos_d;
    phase_e             phase_q;

    // Next position and look-ahead sync decode so the registered sync lines up with pos
    always_comb begin
        wrap_o = advance_i && (pos_q == c_LAST);
        pos_d  = pos_q;
        if (advance_i) begin
            pos_d = wrap_o ? '0 : pos_q + 1'b1;
        end
        sync_next_o = (pos_d >= c_SYNC_START) && (pos_d <= c_LAST_SYNC);
    end

    // Position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Region FSM, stepping at the last position of each region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_ACTIVE;
        end else if (advance_i) begin
            case (phase_q)
                PH_ACTIVE: if (pos_q == c_LAST_ACTIVE) phase_q <= PH_FRONT;
                PH_FRONT:  if (pos_q == c_LAST_FRONT)  phase_q <= PH_SYNC;
                PH_SYNC:   if (pos_q == c_LAST_SYNC)   phase_q <= PH_BACK;
                PH_BACK:   if (pos_q == c_LAST)        phase_q <= PH_ACTIVE;
                default:                               phase_q <= PH_ACTIVE;
            endcase
        end
    end

    assign pos_o   = pos_q;
    assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing (default 640x480@60) with registered
//                syncs, frame counter and clk-domain frame/line strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = c_H_VISIBLE,
    parameter int unsigned H_FRONT         = c_H_FRONT,
    parameter int unsigned H_SYNC          = c_H_SYNC,
    parameter int unsigned H_BACK          = c_H_BACK,
    parameter int unsigned V_VISIBLE       = c_V_VISIBLE,
    parameter int unsigned V_FRONT         = c_V_FRONT,
    parameter int unsigned V_SYNC          = c_V_SYNC,
    parameter int unsigned V_BACK          = c_V_BACK,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               hsync,
    output logic               vsync,
    output logic               video_active,
    output logic [c_POS_W-1:0] pix_x,
    output logic [c_POS_W-1:0] pix_y,
    output logic [c_POS_W-1:0] counter,
    output logic               frame_tick,
    output logic               line_tick
);

    // Level of an idle sync line; XOR with the active-high request gives the pin level
    localparam logic c_SYNC_OFF = SYNC_ACTIVE_LOW;

    logic   h_sync_next;
    logic   h_wrap;
    phase_e h_phase;
    logic   v_sync_next;
    logic   v_wrap;
    phase_e v_phase;

    vga_axis_timer #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance_i   (1'b1),
        .pos_o       (pix_x),
        .phase_o     (h_phase),
        .sync_next_o (h_sync_next),
        .wrap_o      (h_wrap)
    );

    vga_axis_timer #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance_i   (h_wrap),
        .pos_o       (pix_y),
        .phase_o     (v_phase),
        .sync_next_o (v_sync_next),
        .wrap_o      (v_wrap)
    );

    logic               hsync_q;
    logic               vsync_q;
    logic               vsync_on_q;
    logic               frame_tick_q;
    logic [c_POS_W-1:0] counter_q;

    // Registered syncs, frame strobe on the first vsync clock, frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q      <= c_SYNC_OFF;
            vsync_q      <= c_SYNC_OFF;
            vsync_on_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            counter_q    <= '0;
        end else begin
            hsync_q      <= h_sync_next ^ c_SYNC_OFF;
            vsync_q      <= v_sync_next ^ c_SYNC_OFF;
            vsync_on_q   <= v_sync_next;
            frame_tick_q <= v_sync_next && !vsync_on_q;
            if (h_wrap && v_wrap) begin
                counter_q <= counter_q + 1'b1;
            end
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign frame_tick   = frame_tick_q;
    assign counter      = counter_q;
    assign video_active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign line_tick    = (pix_x == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed self-checking bench. A default 640x480 instance
//                covers line-level timing and async reset; a shrunken
//                instance (7 clocks x 6 lines) covers frame-level behaviour
//                and the 1024-frame counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_s_n;

    logic       hsync, vsync, video_active, frame_tick, line_tick;
    logic [9:0] pix_x, pix_y, counter;

    logic       s_hsync, s_vsync, s_va, s_ft, s_lt;
    logic [9:0] s_pix_x, s_pix_y, s_counter;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_active (video_active),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .counter      (counter),
        .frame_tick   (frame_tick),
        .line_tick    (line_tick)
    );

    // Small raster: H = 4/1/1/1 (total 7), V = 3/1/1/1 (total 6), 42 clocks per frame
    vga_timing_gen #(
        .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
        .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_ACTIVE_LOW (1'b1)
    ) u_small (
        .clk          (clk),
        .rst_n        (rst_s_n),
        .hsync        (s_hsync),
        .vsync        (s_vsync),
        .video_active (s_va),
        .pix_x        (s_pix_x),
        .pix_y        (s_pix_y),
        .counter      (s_counter),
        .frame_tick   (s_ft),
        .line_tick    (s_lt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int x, y;
        int e_x, e_y, e_lt, e_hs, e_va, e_vs, e_ft, e_cnt;
        int c_lt, c_hs, c_va, c_vs, c_ft, hs_first, vs_first, cyc;
        logic [9:0] cnt41, cnt42, cnt_a, cnt_b;

        // ---------------- reset values ----------------
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pix_x",   32'(pix_x), 0);
        chk("rst_pix_y",   32'(pix_y), 0);
        chk("rst_counter", 32'(counter), 0);
        chk("rst_ftick",   32'(frame_tick), 0);
        chk("rst_hsync",   32'(hsync), 1);
        chk("rst_vsync",   32'(vsync), 1);
        chk("rst_ltick",   32'(line_tick), 1);
        chk("rst_vactive", 32'(video_active), 1);
        chk("rst_s_vsync", 32'(s_vsync), 1);

        // ---------------- first line of default raster ----------------
        rst_n = 1'b1;
        e_x = 0; e_y = 0; e_lt = 0; e_hs = 0; e_va = 0;
        c_lt = 0; c_hs = 0; c_va = 0; hs_first = -1;
        for (int k = 0; k <= 800; k++) begin
            x = k % 800;
            y = k / 800;
            if (pix_x !== 10'(x)) e_x++;
            if (pix_y !== 10'(y)) e_y++;
            if (line_tick !== (x == 0)) e_lt++;
            if (hsync !== !(x >= 656 && x <= 751)) e_hs++;
            if (video_active !== (x < 640)) e_va++;
            if (line_tick === 1'b1) c_lt++;
            if (hsync === 1'b0) begin
                c_hs++;
                if (hs_first < 0) hs_first = x;
            end
            if (k < 800 && video_active === 1'b1) c_va++;
            if (k < 800) @(negedge clk);
        end
        chk("line_x_seq",      32'(e_x), 0);
        chk("line_y_seq",      32'(e_y), 0);
        chk("line_y_at_800",   32'(pix_y), 1);
        chk("line_tick_pos",   32'(e_lt), 0);
        chk("line_tick_cnt",   32'(c_lt), 2);
        chk("hsync_pattern",   32'(e_hs), 0);
        chk("hsync_low_cnt",   32'(c_hs), 96);
        chk("hsync_first_x",   32'(hs_first), 656);
        chk("vactive_pattern", 32'(e_va), 0);
        chk("vactive_cnt",     32'(c_va), 640);

        // ---------------- async reset while hsync asserted ----------------
        repeat (700) @(negedge clk);
        chk("pre_rst_x",     32'(pix_x), 700);
        chk("pre_rst_hsync", 32'(hsync), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pix_x", 32'(pix_x), 0);
        chk("arst_pix_y", 32'(pix_y), 0);
        chk("arst_hsync", 32'(hsync), 1);
        chk("arst_ltick", 32'(line_tick), 1);
        chk("arst_vact",  32'(video_active), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_x", 32'(pix_x), 1);

        // ---------------- small raster: 1025 frames ----------------
        rst_s_n = 1'b1;
        e_x = 0; e_hs = 0; e_vs = 0; e_va = 0; e_lt = 0; e_ft = 0; e_cnt = 0;
        c_vs = 0; c_va = 0; c_lt = 0; c_ft = 0; vs_first = -1;
        cnt41 = '0; cnt42 = '0; cnt_a = '0; cnt_b = '0;
        for (int k = 0; k <= 43050; k++) begin
            x = k % 7;
            y = (k / 7) % 6;
            if (s_pix_x !== 10'(x) || s_pix_y !== 10'(y)) e_x++;
            if (s_hsync !== (x != 5)) e_hs++;
            if (s_vsync !== (y != 4)) e_vs++;
            if (s_va !== (x < 4 && y < 3)) e_va++;
            if (s_lt !== (x == 0)) e_lt++;
            if (s_ft !== (x == 0 && y == 4)) e_ft++;
            if (s_counter !== 10'((k / 42) % 1024)) e_cnt++;
            if (k < 42) begin
                if (s_vsync === 1'b0) begin
                    c_vs++;
                    if (vs_first < 0) vs_first = k;
                end
                if (s_va === 1'b1) c_va++;
                if (s_lt === 1'b1) c_lt++;
            end
            if (k < 43050 && s_ft === 1'b1) c_ft++;
            if (k == 41)    cnt41 = s_counter;
            if (k == 42)    cnt42 = s_counter;
            if (k == 43007) cnt_a = s_counter;
            if (k == 43008) cnt_b = s_counter;
            if (k < 43050) @(negedge clk);
        end
        chk("s_pos_seq",       32'(e_x), 0);
        chk("s_hsync_pattern", 32'(e_hs), 0);
        chk("s_vsync_pattern", 32'(e_vs), 0);
        chk("s_vactive_patt",  32'(e_va), 0);
        chk("s_ltick_pattern", 32'(e_lt), 0);
        chk("s_ftick_pattern", 32'(e_ft), 0);
        chk("s_counter_seq",   32'(e_cnt), 0);
        chk("s_vsync_low_cnt", 32'(c_vs), 7);
        chk("s_vsync_first",   32'(vs_first), 28);
        chk("s_vactive_cnt",   32'(c_va), 12);
        chk("s_ltick_cnt",     32'(c_lt), 6);
        chk("s_ftick_cnt",     32'(c_ft), 1025);
        chk("s_cnt_before_f1", 32'(cnt41), 0);
        chk("s_cnt_after_f1",  32'(cnt42), 1);
        chk("s_cnt_max",       32'(cnt_a), 1023);
        chk("s_cnt_wrap",      32'(cnt_b), 0);

        // ---------------- small raster: mid-frame async reset ----------------
        repeat (20) @(negedge clk);
        chk("s_pre_rst_x",  32'(s_pix_x), 6);
        chk("s_pre_rst_y",  32'(s_pix_y), 2);
        chk("s_pre_rst_va", 32'(s_va), 0);
        #1 rst_s_n = 1'b0;
        #1;
        chk("s_arst_x",   32'(s_pix_x), 0);
        chk("s_arst_y",   32'(s_pix_y), 0);
        chk("s_arst_cnt", 32'(s_counter), 0);
        chk("s_arst_va",  32'(s_va), 1);
        chk("s_arst_lt",  32'(s_lt), 1);
        chk("s_arst_hs",  32'(s_hsync), 1);
        chk("s_arst_vs",  32'(s_vsync), 1);
        @(negedge clk);
        rst_s_n = 1'b1;
        cyc = 0;
        while (s_ft !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("s_ftick_after_rst", 32'(cyc), 28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
